// File: rtl/mem_march_pkg.sv
// rtl/mem_march_pkg.sv - shared types and helpers for the memory march self-test master
package mem_march_pkg;

    // Width of the helper arithmetic; callers truncate to their own word width.
    localparam int ExpWidth = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Number of words addressed by an address bus of the given width.
    function automatic int mem_size(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Expected word at an address: seed xor address, both zero-extended.
    function automatic logic [ExpWidth-1:0] exp_word(input logic [ExpWidth-1:0] seed,
                                                     input logic [ExpWidth-1:0] addr);
        return seed ^ addr;
    endfunction

endpackage

// File: rtl/mem_march_cmp.sv
// rtl/mem_march_cmp.sv - read-back compare pipeline with saturating error count
module mem_march_cmp
    import mem_march_pkg::*;
#(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 4,
    parameter int CntWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 rd_en_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] seed_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic [CntWidth-1:0]  err_cnt_o,
    output logic [AddrWidth-1:0] first_err_addr_o
);

    logic                 cmp_valid_q;
    logic [AddrWidth-1:0] cmp_addr_q;
    logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0] first_err_q, first_err_d;
    logic [DataWidth-1:0] exp_data;
    logic                 mismatch;

    assign exp_data = DataWidth'(exp_word(ExpWidth'(seed_i), ExpWidth'(cmp_addr_q)));
    assign mismatch = cmp_valid_q && (rdata_i != exp_data);

    // Next error count saturates at all-ones; first failing address latched only from zero.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (mismatch) begin
            if (err_cnt_q != {CntWidth{1'b1}}) begin
                err_cnt_d = err_cnt_q + CntWidth'(1);
            end
            if (err_cnt_q == '0) begin
                first_err_d = cmp_addr_q;
            end
        end
    end

    // Delay the read address by one cycle to line up with the registered read data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else if (clr_i) begin
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            cmp_valid_q <= rd_en_i;
            cmp_addr_q  <= addr_i;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule

// File: rtl/mem_march_master.sv
// rtl/mem_march_master.sv - write/read-back march self-test driver for a 1-cycle-read memory
module mem_march_master
    import mem_march_pkg::*;
#(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 4,
    parameter int CntWidth  = 8
) (
    input  logic                 Clk_i,
    input  logic                 Reset_n_i,
    input  logic                 Start_i,
    input  logic [DataWidth-1:0] Seed_i,
    output logic [AddrWidth-1:0] Mem_Addr_o,
    output logic [DataWidth-1:0] Mem_Data_o,
    output logic                 Mem_WR_o,
    input  logic [DataWidth-1:0] Mem_Data_i,
    output logic                 Busy_o,
    output logic                 Done_o,
    output logic                 Pass_o,
    output logic [CntWidth-1:0]  ErrCount_o,
    output logic [AddrWidth-1:0] FirstErrAddr_o
);

    localparam int                   Size     = mem_size(AddrWidth);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Size - 1);

    state_e               state_q;
    logic [DataWidth-1:0] seed_q;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q;
    logic                 wr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_valid_q;
    logic                 start_acc;
    logic                 rd_en;

    assign start_acc = (state_q == ST_IDLE) && Start_i;
    assign rd_en     = (state_q == ST_READ);
    assign addr_d    = addr_q + AddrWidth'(1);

    // Sequencer: write every word, read every word, one drain cycle, one done cycle.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q      <= ST_IDLE;
            seed_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wr_q    <= 1'b0;
                    wdata_q <= '0;
                    if (Start_i) begin
                        seed_q       <= Seed_i;
                        addr_q       <= '0;
                        wr_q         <= 1'b1;
                        wdata_q      <= DataWidth'(exp_word(ExpWidth'(Seed_i), '0));
                        busy_q       <= 1'b1;
                        pass_valid_q <= 1'b0;
                        state_q      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_q <= addr_d;
                    if (addr_q == LastAddr) begin
                        wr_q    <= 1'b0;
                        wdata_q <= '0;
                        state_q <= ST_READ;
                    end else begin
                        wdata_q <= DataWidth'(exp_word(ExpWidth'(seed_q), ExpWidth'(addr_d)));
                    end
                end
                ST_READ: begin
                    // Hold the last address so the drain cycle issues no new one.
                    if (addr_q == LastAddr) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        addr_q <= addr_d;
                    end
                end
                ST_DRAIN: begin
                    done_q       <= 1'b1;
                    pass_valid_q <= 1'b1;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    mem_march_cmp #(
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth),
        .CntWidth (CntWidth)
    ) u_cmp (
        .clk_i           (Clk_i),
        .rst_n_i         (Reset_n_i),
        .clr_i           (start_acc),
        .rd_en_i         (rd_en),
        .addr_i          (addr_q),
        .seed_i          (seed_q),
        .rdata_i         (Mem_Data_i),
        .err_cnt_o       (ErrCount_o),
        .first_err_addr_o(FirstErrAddr_o)
    );

    assign Mem_Addr_o = addr_q;
    assign Mem_Data_o = wdata_q;
    assign Mem_WR_o   = wr_q;
    assign Busy_o     = busy_q;
    assign Done_o     = done_q;
    // The last compare lands on the same edge that enters DONE, so pass is derived from the count.
    assign Pass_o     = pass_valid_q && (ErrCount_o == '0);

endmodule
